reimu_shot_scheduler: RTL and testbench

Controller for the player-bullet datapath. It owns a pool of NSLOT bullet slots and does four jobs: allocates a free slot when the fire button is held, advances all live bullets once per frame, retires bullets that leave the top of the screen or are reported hit, and enforces a frame-based fire cooldown. It sits between the input/player logic (reimux/reimuy, fire), the collision logic (hit), and the renderer (slot positions and active flags).

---
 rtl/reimu_shot_scheduler.sv | 122 ++++++++++++
 tb/tb_reimu_shot_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reimu_shot_scheduler.sv
// Player-bullet slot pool: per-frame advance, top-of-screen retirement,
// hit clearing, and cooldown-limited spawning into the lowest free slot.
module reimu_shot_scheduler #(
    parameter int NSLOT    = 4,
    parameter int SPEED    = 20,
    parameter int COOLDOWN = 6
) (
    input  logic                  clk_22,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  fire,
    input  logic [9:0]            reimux,
    input  logic [9:0]            reimuy,
    input  logic [NSLOT-1:0]      hit,
    output logic [10*NSLOT-1:0]   bullet_x,
    output logic [10*NSLOT-1:0]   bullet_y,
    output logic [NSLOT-1:0]      bullet_active,
    output logic                  fire_ack,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        SPAWN = 2'd2
    } state_t;

    localparam logic [9:0] SPEED_W    = 10'(SPEED);
    localparam logic [7:0] COOLDOWN_W = 8'(COOLDOWN);

    state_t           state_reg;
    state_t           state_next;
    logic [7:0]       cd_reg;
    logic [NSLOT-1:0] active_reg;
    logic [NSLOT-1:0] spawn_sel;
    logic             any_free;
    logic             spawn_go;

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Ticks seen while MOVE/SPAWN are in flight are simply dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_tick) state_next = MOVE;
            MOVE:    state_next = SPAWN;
            SPAWN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg == MOVE) || (state_reg == SPAWN);
        fire_ack = spawn_go;
    end

    always_comb begin
        spawn_sel = '0;
        any_free  = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!active_reg[i] && !any_free) begin
                spawn_sel[i] = 1'b1;
                any_free     = 1'b1;
            end
        end
    end

    assign spawn_go = (state_reg == SPAWN) && fire && (cd_reg == 8'd0) && any_free;

    always_ff @(posedge clk_22 or posedge rst) begin
        if (rst) begin
            cd_reg <= 8'd0;
        end else if (spawn_go) begin
            cd_reg <= COOLDOWN_W;
        end else if ((state_reg == MOVE) && (cd_reg != 8'd0)) begin
            cd_reg <= cd_reg - 8'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic [9:0] x_reg;
            logic [9:0] y_reg;
            logic       act_reg;

            // Hit wins over move/retire; a slot that was free when sampled
            // cannot be hit, so a spawn into it always lands.
            always_ff @(posedge clk_22 or posedge rst) begin
                if (rst) begin
                    x_reg   <= 10'd0;
                    y_reg   <= 10'd0;
                    act_reg <= 1'b0;
                end else if (act_reg && hit[gi]) begin
                    act_reg <= 1'b0;
                end else if (act_reg && (state_reg == MOVE)) begin
                    if (y_reg < SPEED_W) begin
                        act_reg <= 1'b0;
                    end else begin
                        y_reg <= y_reg - SPEED_W;
                    end
                end else if (spawn_go && spawn_sel[gi]) begin
                    x_reg   <= reimux;
                    y_reg   <= reimuy;
                    act_reg <= 1'b1;
                end
            end

            assign active_reg[gi]          = act_reg;
            assign bullet_x[10*gi +: 10]   = x_reg;
            assign bullet_y[10*gi +: 10]   = y_reg;
        end
    endgenerate

    assign bullet_active = active_reg;

endmodule

// File: tb/tb_reimu_shot_scheduler.sv
// Randomized and directed checks of reimu_shot_scheduler against a
// frame-level behavioural model of the bullet pool.
module tb_reimu_shot_scheduler;
    localparam int NSLOT    = 4;
    localparam int SPEED    = 20;
    localparam int COOLDOWN = 6;

    logic                 clk_22 = 1'b0;
    logic                 rst = 1'b1;
    logic                 frame_tick = 1'b0;
    logic                 fire = 1'b0;
    logic [9:0]           reimux = 10'd0;
    logic [9:0]           reimuy = 10'd0;
    logic [NSLOT-1:0]     hit = '0;
    logic [10*NSLOT-1:0]  bullet_x;
    logic [10*NSLOT-1:0]  bullet_y;
    logic [NSLOT-1:0]     bullet_active;
    logic                 fire_ack;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    bit m_act[NSLOT];
    int m_x[NSLOT];
    int m_y[NSLOT];
    int m_cd;

    reimu_shot_scheduler #(.NSLOT(NSLOT), .SPEED(SPEED), .COOLDOWN(COOLDOWN)) dut (
        .clk_22(clk_22), .rst(rst), .frame_tick(frame_tick), .fire(fire),
        .reimux(reimux), .reimuy(reimuy), .hit(hit),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .fire_ack(fire_ack), .busy(busy)
    );

    always #5 clk_22 = ~clk_22;

    task automatic step();
        @(posedge clk_22);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_act[i] = 1'b0;
            m_x[i] = 0;
            m_y[i] = 0;
        end
        m_cd = 0;
    endtask

    function automatic logic [NSLOT-1:0] exp_act();
        logic [NSLOT-1:0] v;
        for (int i = 0; i < NSLOT; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [10*NSLOT-1:0] exp_x();
        logic [10*NSLOT-1:0] v;
        for (int i = 0; i < NSLOT; i++) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    function automatic logic [10*NSLOT-1:0] exp_y();
        logic [10*NSLOT-1:0] v;
        for (int i = 0; i < NSLOT; i++) v[10*i +: 10] = 10'(m_y[i]);
        return v;
    endfunction

    // Drives one full frame (IDLE tick, MOVE, SPAWN) and advances the model.
    task automatic do_frame(input bit f, input int px, input int py,
                            input logic [NSLOT-1:0] h_idle, input logic [NSLOT-1:0] h_move,
                            input logic [NSLOT-1:0] h_spawn, input bit tick_extra,
                            output bit exp_ack, output bit ack_spawn,
                            output int ack_other, output bit busy_ok);
        int free_slot;
        frame_tick = 1'b1;
        hit = h_idle;
        fire = 1'b0;
        ack_other = int'(fire_ack);
        busy_ok = (busy === 1'b0);
        for (int i = 0; i < NSLOT; i++) if (m_act[i] && h_idle[i]) m_act[i] = 1'b0;
        step();
        frame_tick = tick_extra;
        hit = h_move;
        busy_ok = busy_ok && (busy === 1'b1);
        ack_other += int'(fire_ack);
        for (int i = 0; i < NSLOT; i++) begin
            if (m_act[i]) begin
                if (h_move[i]) m_act[i] = 1'b0;
                else if (m_y[i] < SPEED) m_act[i] = 1'b0;
                else m_y[i] = m_y[i] - SPEED;
            end
        end
        if (m_cd > 0) m_cd--;
        step();
        fire = f;
        reimux = 10'(px);
        reimuy = 10'(py);
        hit = h_spawn;
        #1;
        busy_ok = busy_ok && (busy === 1'b1);
        ack_spawn = (fire_ack === 1'b1);
        free_slot = -1;
        for (int i = 0; i < NSLOT; i++) if (!m_act[i] && free_slot < 0) free_slot = i;
        exp_ack = f && (m_cd == 0) && (free_slot >= 0);
        for (int i = 0; i < NSLOT; i++) if (m_act[i] && h_spawn[i]) m_act[i] = 1'b0;
        if (exp_ack) begin
            m_act[free_slot] = 1'b1;
            m_x[free_slot] = px;
            m_y[free_slot] = py;
            m_cd = COOLDOWN;
        end
        step();
        frame_tick = 1'b0;
        fire = 1'b0;
        hit = '0;
        ack_other += int'(fire_ack);
        busy_ok = busy_ok && (busy === 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bit ea, aa, bo;
        int ao;
        do_reset();
        checks++;
        if (bullet_active !== '0 || bullet_x !== '0 || bullet_y !== '0 || fire_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state act=%b x=%h y=%h ack=%b busy=%b required all zero",
                     bullet_active, bullet_x, bullet_y, fire_ack, busy);
        end
        do_frame(1, 100, 600, '0, '0, '0, 0, ea, aa, ao, bo);
        for (int k = 0; k < 6; k++) do_frame(k == 5, 200, 700, '0, '0, '0, 0, ea, aa, ao, bo);
        checks++;
        if (bullet_active !== 4'b0011) begin
            failures++;
            $display("FAIL reset_setup act=%b required 0011", bullet_active);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        fire = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bullet_active !== '0 || bullet_x !== '0 || bullet_y !== '0 || fire_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_spawn act=%b x=%h y=%h ack=%b busy=%b required all zero",
                     bullet_active, bullet_x, bullet_y, fire_ack, busy);
        end
        fire = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        $display("test_reset: mid-spawn reset act=%b busy=%b", bullet_active, busy);
    endtask

    task automatic test_idle();
        bit ea, aa, bo;
        int ao;
        do_frame(0, 5, 5, '0, '0, '0, 0, ea, aa, ao, bo);
        checks++;
        if (!bo || aa || ao != 0 || bullet_active !== '0 || bullet_y !== '0) begin
            failures++;
            $display("FAIL idle_frame busy_ok=%b ack=%b other=%0d act=%b required busy pulse, no ack, no slots",
                     bo, aa, ao, bullet_active);
        end
        $display("test_idle: busy_ok=%b act=%b", bo, bullet_active);
    endtask

    task automatic test_single_shot();
        bit ea, aa, bo;
        int ao;
        do_frame(1, 300, 400, '0, '0, '0, 0, ea, aa, ao, bo);
        checks++;
        if (!aa || ao != 0 || bullet_active !== 4'b0001 || bullet_x[9:0] !== 10'd300 || bullet_y[9:0] !== 10'd400) begin
            failures++;
            $display("FAIL single_spawn ack=%b other=%0d act=%b x=%0d y=%0d required ack, 0001, (300,400)",
                     aa, ao, bullet_active, bullet_x[9:0], bullet_y[9:0]);
        end
        for (int k = 1; k <= 2; k++) begin
            do_frame(0, 0, 0, '0, '0, '0, 0, ea, aa, ao, bo);
            checks++;
            if (bullet_y[9:0] !== 10'(400 - 20*k) || bullet_x[9:0] !== 10'd300 || bullet_active !== 4'b0001) begin
                failures++;
                $display("FAIL single_move%0d x=%0d y=%0d act=%b required (300,%0d) active",
                         k, bullet_x[9:0], bullet_y[9:0], bullet_active, 400 - 20*k);
            end
        end
        $display("test_single_shot: y=%0d", bullet_y[9:0]);
    endtask

    task automatic test_cooldown();
        bit ea, aa, bo;
        int ao;
        int acks;
        do_reset();
        acks = 0;
        for (int k = 1; k <= 13; k++) begin
            do_frame(1, $urandom_range(0, 1023), $urandom_range(500, 1000), '0, '0, '0, 0, ea, aa, ao, bo);
            acks += int'(aa) + ao;
            checks++;
            if (aa !== (k == 1 || k == 7 || k == 13)) begin
                failures++;
                $display("FAIL cooldown_tick%0d ack=%b required %b", k, aa, (k == 1 || k == 7 || k == 13));
            end
        end
        checks++;
        if (acks != 3 || bullet_active !== 4'b0111 || bullet_x !== exp_x() || bullet_y !== exp_y()) begin
            failures++;
            $display("FAIL cooldown_total acks=%0d act=%b required 3 acks, 0111", acks, bullet_active);
        end
        $display("test_cooldown: acks=%0d act=%b", acks, bullet_active);
    endtask

    task automatic test_top_exit();
        bit ea, aa, bo;
        int ao;
        do_reset();
        do_frame(1, 50, 25, '0, '0, '0, 0, ea, aa, ao, bo);
        do_frame(0, 0, 0, '0, '0, '0, 0, ea, aa, ao, bo);
        checks++;
        if (bullet_y[9:0] !== 10'd5 || bullet_active !== 4'b0001) begin
            failures++;
            $display("FAIL top_exit_move y=%0d act=%b required 5 active", bullet_y[9:0], bullet_active);
        end
        do_frame(0, 0, 0, '0, '0, '0, 0, ea, aa, ao, bo);
        checks++;
        if (bullet_y[9:0] !== 10'd5 || bullet_active !== 4'b0000) begin
            failures++;
            $display("FAIL top_exit_retire y=%0d act=%b required 5 inactive", bullet_y[9:0], bullet_active);
        end
        $display("test_top_exit: y=%0d act=%b", bullet_y[9:0], bullet_active);
    endtask

    task automatic test_pool_full();
        bit ea, aa, bo;
        int ao;
        do_reset();
        for (int k = 1; k <= 24; k++) do_frame(1, k, 1000, '0, '0, '0, 0, ea, aa, ao, bo);
        do_frame(1, 9, 900, '0, '0, '0, 0, ea, aa, ao, bo);
        checks++;
        if (aa || ao != 0 || bullet_active !== 4'b1111) begin
            failures++;
            $display("FAIL pool_full_noack ack=%b act=%b required no ack, 1111", aa, bullet_active);
        end
        do_frame(1, 123, 777, '0, 4'b0100, '0, 0, ea, aa, ao, bo);
        checks++;
        if (!aa || bullet_active !== 4'b1111 || bullet_x[29:20] !== 10'd123 || bullet_y[29:20] !== 10'd777) begin
            failures++;
            $display("FAIL pool_full_respawn ack=%b act=%b x2=%0d y2=%0d required ack, 1111, (123,777)",
                     aa, bullet_active, bullet_x[29:20], bullet_y[29:20]);
        end
        $display("test_pool_full: act=%b slot2=(%0d,%0d)", bullet_active, bullet_x[29:20], bullet_y[29:20]);
    endtask

    task automatic test_hit_priority();
        bit ea, aa, bo;
        int ao;
        do_reset();
        do_frame(1, 10, 400, '0, '0, '0, 0, ea, aa, ao, bo);
        do_frame(0, 0, 0, '0, 4'b1001, '0, 0, ea, aa, ao, bo);
        checks++;
        if (bullet_active !== 4'b0000 || bullet_y[9:0] !== 10'd400 || bullet_y[39:30] !== 10'd0) begin
            failures++;
            $display("FAIL hit_priority act=%b y0=%0d y3=%0d required 0000, 400, 0",
                     bullet_active, bullet_y[9:0], bullet_y[39:30]);
        end
        $display("test_hit_priority: act=%b y0=%0d", bullet_active, bullet_y[9:0]);
    endtask

    task automatic test_random();
        bit ea, aa, bo;
        int ao;
        do_reset();
        for (int k = 0; k < 150; k++) begin
            logic [NSLOT-1:0] hi, hm, hs;
            hi = NSLOT'($urandom & $urandom & $urandom);
            hm = NSLOT'($urandom & $urandom & $urandom);
            hs = NSLOT'($urandom & $urandom & $urandom);
            do_frame($urandom_range(0, 9) < 7, $urandom_range(0, 1023), $urandom_range(0, 1023),
                     hi, hm, hs, $urandom_range(0, 1), ea, aa, ao, bo);
            checks++;
            if (aa !== ea || ao != 0 || !bo) begin
                failures++;
                $display("FAIL rand_ack%0d ack=%b other=%0d busy_ok=%b required ack=%b other=0 busy_ok=1",
                         k, aa, ao, bo, ea);
            end
            checks++;
            if (bullet_active !== exp_act() || bullet_x !== exp_x() || bullet_y !== exp_y()) begin
                failures++;
                $display("FAIL rand_state%0d act=%b x=%h y=%h required act=%b x=%h y=%h",
                         k, bullet_active, bullet_x, bullet_y, exp_act(), exp_x(), exp_y());
            end
            $display("frame %0d ack=%b act=%b", k, aa, bullet_active);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_single_shot();
        test_cooldown();
        test_top_exit();
        test_pool_full();
        test_hit_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
